alu_operand_collector: RTL
==========================

Name: alu_operand_collector

Overview:
Upstream issue stage for ALU_DESIGN. Accepts operand/command beats from the stimulus or host side over a valid/ready handshake, and collects OPA and OPB when they arrive in separate beats. Drives the ALU's CE/MODE/CMD/INP_VALID/CIN/OPA/OPB with a one-cycle issue pulse. Enforces the ALU's 16-cycle operand-pairing window and holds off new beats while a command is in flight.

Parameters:
DW, 8, operand width (matches ALU DW)
CW, 4, command width (matches ALU CW)
TIMEOUT, 16, cycles to wait for a missing operand before a partial issue
ALU_LAT, 2, cycles after an issue before the next issue is allowed

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-low reset
IN_VALID  in  1  beat valid
IN_READY  out  1  collector can accept a beat
IN_SEL  in  2  operands carried: 01=OPA, 10=OPB, 11=both; 00 = illegal
IN_MODE  in  1  1=arithmetic, 0=logic
IN_CMD  in  CW  command
IN_CIN  in  1  carry in
IN_OPA  in  DW  operand A
IN_OPB  in  DW  operand B
ALU_CE  out  1  issue strobe (clock enable to ALU)
ALU_MODE  out  1  registered mode
ALU_CMD  out  CW  registered command
ALU_CIN  out  1  registered carry
ALU_INP_VALID  out  2  operand mask presented to the ALU
ALU_OPA  out  DW  registered operand A
ALU_OPB  out  DW  registered operand B
TIMEOUT_ERR  out  1  1-cycle pulse on a partial issue caused by timeout
BUSY  out  1  state != IDLE

Behaviour:
- Reset (RST=0, async): state IDLE; every output 0 except IN_READY=0. IN_READY rises on the first clock edge after RST deasserts. Held operands, mask, and counters cleared. Reset mid-collect or mid-wait discards the pending command; no issue occurs.
- Accept: a beat is accepted when IN_VALID & IN_READY at a rising edge.
- Required mask: REQ = op_req(IN_MODE, IN_CMD).
  - Arithmetic: CMD 4,5 → 01; CMD 6,7 → 10; all others → 11.
  - Logic: CMD 6,8,9 → 01; CMD 7,10,11 → 10; all others → 11.
- States:
  - IDLE (IN_READY=1): on accept, latch MODE/CMD/CIN/REQ and the supplied operands; HAVE = IN_SEL.
    - If (HAVE & REQ) == REQ → ISSUE.
    - Otherwise → COLLECT, with the counter cleared.
  - COLLECT (IN_READY=1): counter increments every cycle with no completing beat.
    - An accepted beat ORs its IN_SEL into HAVE and overwrites the operands it carries.
    - MODE/CMD/CIN of later beats are ignored.
    - When REQ is satisfied → ISSUE.
    - When the counter reaches TIMEOUT-1 without completion → ISSUE with TIMEOUT_ERR=1.
    - A completing beat in the same cycle as expiry wins: normal issue, no error.
  - ISSUE (IN_READY=0, one cycle): ALU_CE=1, ALU_INP_VALID = HAVE & REQ, outputs driven from the held registers → WAIT.
  - WAIT (IN_READY=0): ALU_CE=0 for ALU_LAT cycles → IDLE.
- Latency: a complete beat in IDLE at edge N gives ALU_CE=1 in cycle N+1. The next beat can be accepted ALU_LAT+1 cycles after issue.
- ALU_MODE/CMD/CIN/OPA/OPB hold their last issued values outside ISSUE. ALU_INP_VALID=00 whenever ALU_CE=0.
- IN_SEL=00 with IN_VALID: the beat is accepted and dropped; no state change.
- Operand bits not in HAVE are driven as 0.
- Counter width: $clog2(TIMEOUT)+1; it saturates and never wraps.

Decomposition:
- alu_pkg holds:
  - state enum (IDLE, COLLECT, ISSUE, WAIT)
  - SEL_A/SEL_B/SEL_AB constants
  - op_req(mode, cmd) function
  - CMD code constants shared with the ALU and the reference model
- One natural sub-module: alu_timeout_ctr (clear, enable, expire output).

Test Plan:
1. Reset mid-COLLECT: RST=0 while HAVE=01 → all outputs 0 immediately; no ALU_CE after release.
2. Single beat, MODE=1, CMD=0 (ADD), SEL=11, OPA=8'h12, OPB=8'h34 → next cycle ALU_CE=1, INP_VALID=11, OPA=12, OPB=34; IN_READY low for 3 cycles.
3. Split beats: SEL=01 OPA=8'hA5, 5 idle cycles, SEL=10 OPB=8'h0F → one issue with INP_VALID=11, A5/0F, TIMEOUT_ERR=0.
4. Timeout: MODE=1 CMD=0 with SEL=01 only → issue after exactly 16 COLLECT cycles with INP_VALID=01 and TIMEOUT_ERR pulse; ALU reports ERR=1.
5. Expiry race: the OPB beat arrives in the 16th COLLECT cycle → normal issue, INP_VALID=11, no TIMEOUT_ERR.
6. Single-operand command: MODE=1 CMD=4 (INC_A), SEL=01 OPA=8'hFF → immediate issue with INP_VALID=01, OPB=0; ALU RES=9'h100.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared states, operand-select codes, command codes and operand-requirement lookup
// Contents: state_t, SEL_* masks, CMD_* codes (arithmetic and logic sets), op_req(mode, cmd)
package alu_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, WAIT} state_t;

    localparam logic [1:0] SEL_A  = 2'b01;
    localparam logic [1:0] SEL_B  = 2'b10;
    localparam logic [1:0] SEL_AB = 2'b11;

    localparam int CMD_W = 4;

    localparam logic [CMD_W-1:0] CMD_ADD     = 4'd0;
    localparam logic [CMD_W-1:0] CMD_SUB     = 4'd1;
    localparam logic [CMD_W-1:0] CMD_ADD_CIN = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SUB_CIN = 4'd3;
    localparam logic [CMD_W-1:0] CMD_INC_A   = 4'd4;
    localparam logic [CMD_W-1:0] CMD_DEC_A   = 4'd5;
    localparam logic [CMD_W-1:0] CMD_INC_B   = 4'd6;
    localparam logic [CMD_W-1:0] CMD_DEC_B   = 4'd7;
    localparam logic [CMD_W-1:0] CMD_CMP     = 4'd8;

    localparam logic [CMD_W-1:0] CMD_AND     = 4'd0;
    localparam logic [CMD_W-1:0] CMD_NAND    = 4'd1;
    localparam logic [CMD_W-1:0] CMD_OR      = 4'd2;
    localparam logic [CMD_W-1:0] CMD_NOR     = 4'd3;
    localparam logic [CMD_W-1:0] CMD_XOR     = 4'd4;
    localparam logic [CMD_W-1:0] CMD_XNOR    = 4'd5;
    localparam logic [CMD_W-1:0] CMD_NOT_A   = 4'd6;
    localparam logic [CMD_W-1:0] CMD_NOT_B   = 4'd7;
    localparam logic [CMD_W-1:0] CMD_SHR1_A  = 4'd8;
    localparam logic [CMD_W-1:0] CMD_SHL1_A  = 4'd9;
    localparam logic [CMD_W-1:0] CMD_SHR1_B  = 4'd10;
    localparam logic [CMD_W-1:0] CMD_SHL1_B  = 4'd11;

    // Which operands a command actually consumes; everything not listed needs both.
    function automatic logic [1:0] op_req(input logic mode, input logic [CMD_W-1:0] cmd);
        if (mode)
            return (cmd == CMD_INC_A || cmd == CMD_DEC_A) ? SEL_A :
                   (cmd == CMD_INC_B || cmd == CMD_DEC_B) ? SEL_B : SEL_AB;
        return (cmd == CMD_NOT_A || cmd == CMD_SHR1_A || cmd == CMD_SHL1_A) ? SEL_A :
               (cmd == CMD_NOT_B || cmd == CMD_SHR1_B || cmd == CMD_SHL1_B) ? SEL_B : SEL_AB;
    endfunction

endpackage

// File: rtl/alu_timeout_ctr.sv
// alu_timeout_ctr: saturating operand-pairing window counter
// Ports: clk, rst_n (async active-low), clr (sync clear, wins), en (count), expire (count == TIMEOUT-1)
module alu_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + 1'b1;

    assign expire = cnt == W'(TIMEOUT - 1);

endmodule

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: pairs split operand beats and issues one-cycle commands to the ALU
// Ports:
//   CLK, RST (async active-low)
//   IN_VALID/IN_READY handshake; IN_SEL operand mask (01 A, 10 B, 11 both, 00 dropped)
//   IN_MODE, IN_CMD, IN_CIN, IN_OPA, IN_OPB: command beat payload
//   ALU_CE issue strobe; ALU_MODE/CMD/CIN/OPA/OPB held issue values; ALU_INP_VALID operand mask
//   TIMEOUT_ERR pulse on a partial issue after the pairing window; BUSY when not IDLE
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int TIMEOUT = 16,
    parameter int ALU_LAT = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [1:0]    IN_SEL,
    input  logic          IN_MODE,
    input  logic [CW-1:0] IN_CMD,
    input  logic          IN_CIN,
    input  logic [DW-1:0] IN_OPA,
    input  logic [DW-1:0] IN_OPB,
    output logic          ALU_CE,
    output logic          ALU_MODE,
    output logic [CW-1:0] ALU_CMD,
    output logic          ALU_CIN,
    output logic [1:0]    ALU_INP_VALID,
    output logic [DW-1:0] ALU_OPA,
    output logic [DW-1:0] ALU_OPB,
    output logic          TIMEOUT_ERR,
    output logic          BUSY
);

    localparam int LW = $clog2(ALU_LAT + 1);

    state_t        state, state_n;
    logic          mode, mode_n, cin, cin_n;
    logic [CW-1:0] cmd, cmd_n;
    logic [1:0]    req, req_n, have, have_n;
    logic [DW-1:0] opa, opa_n, opb, opb_n;
    logic [LW-1:0] lat_cnt;
    logic          acc, first, done, expire, go, lat_done;

    // Beats with an empty mask are consumed by the handshake but otherwise ignored.
    always_comb begin
        acc      = IN_VALID && IN_READY && IN_SEL != 2'b00;
        first    = acc && state == IDLE;
        mode_n   = first ? IN_MODE : mode;
        cmd_n    = first ? IN_CMD : cmd;
        cin_n    = first ? IN_CIN : cin;
        req_n    = first ? op_req(IN_MODE, IN_CMD) : req;
        have_n   = first ? IN_SEL : acc ? have | IN_SEL : have;
        opa_n    = acc && IN_SEL[0] ? IN_OPA : first ? '0 : opa;
        opb_n    = acc && IN_SEL[1] ? IN_OPB : first ? '0 : opb;
        done     = (have_n & req_n) == req_n;
        // A completing beat in the expiry cycle still counts as a normal issue.
        go       = (state == IDLE && first && done) || (state == COLLECT && (done || expire));
        lat_done = lat_cnt == LW'(ALU_LAT - 1);
        state_n  = state == IDLE    ? (go ? ISSUE : first ? COLLECT : IDLE) :
                   state == COLLECT ? (go ? ISSUE : COLLECT) :
                   state == ISSUE   ? WAIT :
                   lat_done         ? IDLE : WAIT;
    end

    alu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (CLK),
        .rst_n  (RST),
        .clr    (state != COLLECT),
        .en     (!done),
        .expire (expire)
    );

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state         <= IDLE;
            mode          <= 1'b0;
            cmd           <= '0;
            cin           <= 1'b0;
            req           <= 2'b00;
            have          <= 2'b00;
            opa           <= '0;
            opb           <= '0;
            lat_cnt       <= '0;
            IN_READY      <= 1'b0;
            BUSY          <= 1'b0;
            ALU_CE        <= 1'b0;
            ALU_MODE      <= 1'b0;
            ALU_CMD       <= '0;
            ALU_CIN       <= 1'b0;
            ALU_INP_VALID <= 2'b00;
            ALU_OPA       <= '0;
            ALU_OPB       <= '0;
            TIMEOUT_ERR   <= 1'b0;
        end else begin
            state         <= state_n;
            mode          <= mode_n;
            cmd           <= cmd_n;
            cin           <= cin_n;
            req           <= req_n;
            have          <= have_n;
            opa           <= opa_n;
            opb           <= opb_n;
            lat_cnt       <= state == WAIT ? lat_cnt + 1'b1 : '0;
            IN_READY      <= state_n == IDLE || state_n == COLLECT;
            BUSY          <= state_n != IDLE;
            ALU_CE        <= go;
            ALU_INP_VALID <= go ? have_n & req_n : 2'b00;
            TIMEOUT_ERR   <= go && !done;
            if (go) begin
                ALU_MODE <= mode_n;
                ALU_CMD  <= cmd_n;
                ALU_CIN  <= cin_n;
                ALU_OPA  <= have_n[0] ? opa_n : '0;
                ALU_OPB  <= have_n[1] ? opb_n : '0;
            end
        end

endmodule
